// File: rtl/sink_d_pkg.sv
// rtl/sink_d_pkg.sv - D-channel sink opcodes and beat-count helpers
package sink_d_pkg;

  // D-channel opcodes; an odd opcode carries data (AccessAckData, GrantData)
  typedef enum logic [2:0] {
    OP_ACCESS_ACK      = 3'd0,
    OP_ACCESS_ACK_DATA = 3'd1,
    OP_HINT_ACK        = 3'd2,
    OP_GRANT           = 3'd4,
    OP_GRANT_DATA      = 3'd5,
    OP_RELEASE_ACK     = 3'd6
  } d_opcode_e;

  // Beats in the largest transfer
  function automatic int calc_beats(input int max_lg_size, input int data_w);
    return (1 << max_lg_size) / (data_w / 8);
  endfunction

  // Width of a beat index; never narrower than one bit
  function automatic int calc_beat_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // Beats minus one for a message; messages without data are a single beat
  function automatic int beats1_calc(input logic has_data, input int size, input int data_w);
    if (!has_data) return 0;
    return ((1 << size) - 1) >> $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/sink_d_fifo.sv
// rtl/sink_d_fifo.sv - registered input FIFO without flow-through
module sink_d_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_data,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enq_fire, deq_fire;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Both sides are held off while reset is asserted so nothing leaks through
  assign enq_ready = reset & (count_q != CNT_W'(DEPTH));
  assign deq_valid = reset & (count_q != '0);
  assign deq_data  = mem_q[rd_ptr_q];
  assign enq_fire  = enq_valid & enq_ready;
  assign deq_fire  = deq_valid & deq_ready;

  // Next pointer, occupancy and storage contents
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (enq_fire) begin
      mem_d[wr_ptr_q] = enq_data;
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end
    if (deq_fire) rd_ptr_d = ptr_next(rd_ptr_q);
    count_d = count_q + CNT_W'(enq_fire) - CNT_W'(deq_fire);
  end

  // Pointer and occupancy registers, cleared by reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy decides what is valid
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/sink_d_param.sv
// rtl/sink_d_param.sv - D-channel sink: beat counting, MSHR response, bank-store writes
module sink_d_param
  import sink_d_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int MAX_LG_SIZE = 6,
  parameter int SIZE_W      = 3,
  parameter int SOURCE_W    = 3,
  parameter int SINK_W      = 3,
  parameter int DEPTH       = 2,
  localparam int BEATS      = calc_beats(MAX_LG_SIZE, DATA_W),
  localparam int BEAT_W     = calc_beat_w(BEATS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_d_valid,
  output logic                io_d_ready,
  input  logic [2:0]          io_d_bits_opcode,
  input  logic [1:0]          io_d_bits_param,
  input  logic [SIZE_W-1:0]   io_d_bits_size,
  input  logic [SOURCE_W-1:0] io_d_bits_source,
  input  logic [SINK_W-1:0]   io_d_bits_sink,
  input  logic                io_d_bits_denied,
  input  logic [DATA_W-1:0]   io_d_bits_data,
  input  logic                io_d_bits_corrupt,
  input  logic                io_bs_adr_ready,
  input  logic                io_grant_safe,
  output logic                io_resp_valid,
  output logic                io_resp_bits_last,
  output logic [2:0]          io_resp_bits_opcode,
  output logic [2:0]          io_resp_bits_param,
  output logic [SOURCE_W-1:0] io_resp_bits_source,
  output logic [SINK_W-1:0]   io_resp_bits_sink,
  output logic                io_resp_bits_denied,
  output logic                io_resp_bits_corrupt,
  output logic [SOURCE_W-1:0] io_source,
  output logic                io_bs_adr_valid,
  output logic                io_bs_adr_bits_noop,
  output logic [BEAT_W-1:0]   io_bs_adr_bits_beat,
  output logic [DATA_W-1:0]   io_bs_dat_data
);

  localparam int PAY_W = 3 + 2 + SIZE_W + SOURCE_W + SINK_W + 1 + DATA_W + 1;

  logic [PAY_W-1:0]    enq_data, deq_data;
  logic                deq_valid, deq_ready, fire;
  logic [2:0]          h_opcode;
  logic [1:0]          h_param;
  logic [SIZE_W-1:0]   h_size;
  logic [SOURCE_W-1:0] h_source;
  logic [SINK_W-1:0]   h_sink;
  logic                h_denied, h_corrupt;
  logic [DATA_W-1:0]   h_data;

  logic [BEAT_W:0]     cnt_q, cnt_d;
  logic                cnt_nz, first, last, corrupt_in;
  logic [BEAT_W-1:0]   beats1, beat;
  logic                corrupt_acc_q, corrupt_acc_d;
  logic [SOURCE_W-1:0] src_q, src_d;
  logic [BEAT_W-1:0]   beat_r_q, beat_r_d;

  assign enq_data = {io_d_bits_opcode, io_d_bits_param, io_d_bits_size, io_d_bits_source,
                     io_d_bits_sink, io_d_bits_denied, io_d_bits_data, io_d_bits_corrupt};

  sink_d_fifo #(.DEPTH(DEPTH), .WIDTH(PAY_W)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (io_d_valid),
    .enq_ready (io_d_ready),
    .enq_data  (enq_data),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_data  (deq_data)
  );

  assign {h_opcode, h_param, h_size, h_source, h_sink, h_denied, h_data, h_corrupt} = deq_data;

  // Beat bookkeeping: once a burst has started it owns the bank store, so grant_safe only gates the first beat
  always_comb begin
    beats1     = BEAT_W'(beats1_calc(h_opcode[0], int'(h_size), DATA_W));
    cnt_nz     = reset & (cnt_q != '0);
    first      = (cnt_q == '0);
    last       = (cnt_q == (BEAT_W+1)'(1)) | (first & (beats1 == '0));
    beat       = first ? '0 : (beats1 + BEAT_W'(1) - cnt_q[BEAT_W-1:0]);
    deq_ready  = io_bs_adr_ready & (cnt_nz | io_grant_safe);
    fire       = deq_valid & deq_ready;
    corrupt_in = h_corrupt & ~h_denied;
    cnt_d      = cnt_q;
    if (fire) cnt_d = first ? {1'b0, beats1} : (cnt_q - (BEAT_W+1)'(1));
    corrupt_acc_d = corrupt_acc_q;
    if (fire) corrupt_acc_d = last ? 1'b0 : (corrupt_acc_q | corrupt_in);
    src_d    = src_q;
    beat_r_d = beat_r_q;
    if (deq_valid) begin
      src_d    = h_source;
      beat_r_d = (BEATS == 1) ? '0 : (beat + BEAT_W'(io_bs_adr_ready));
    end
  end

  // Response and bank-store outputs; the hold registers cover cycles with an empty FIFO
  always_comb begin
    io_resp_valid        = fire & (first | last);
    io_resp_bits_last    = last;
    io_resp_bits_opcode  = h_opcode;
    io_resp_bits_param   = {1'b0, h_param};
    io_resp_bits_source  = h_source;
    io_resp_bits_sink    = h_sink;
    io_resp_bits_denied  = h_denied;
    io_resp_bits_corrupt = corrupt_acc_q | corrupt_in;
    io_source            = deq_valid ? h_source : src_q;
    io_bs_adr_valid      = cnt_nz | (deq_valid & io_grant_safe);
    io_bs_adr_bits_noop  = ~deq_valid | ~h_opcode[0];
    io_bs_adr_bits_beat  = deq_valid ? beat : beat_r_q;
    io_bs_dat_data       = h_data;
  end

  // Burst state registers; reset abandons any partial burst
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q         <= '0;
      corrupt_acc_q <= 1'b0;
      src_q         <= '0;
      beat_r_q      <= '0;
    end else begin
      cnt_q         <= cnt_d;
      corrupt_acc_q <= corrupt_acc_d;
      src_q         <= src_d;
      beat_r_q      <= beat_r_d;
    end
  end

endmodule

// File: tb/tb_sink_d_param.sv
// tb/tb_sink_d_param.sv - scoreboard bench for sink_d_param
module tb_sink_d_param;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_d_valid = 1'b0;
  logic        io_d_ready;
  logic [2:0]  io_d_bits_opcode = '0;
  logic [1:0]  io_d_bits_param = '0;
  logic [2:0]  io_d_bits_size = '0;
  logic [2:0]  io_d_bits_source = '0;
  logic [2:0]  io_d_bits_sink = '0;
  logic        io_d_bits_denied = 1'b0;
  logic [63:0] io_d_bits_data = '0;
  logic        io_d_bits_corrupt = 1'b0;
  logic        io_bs_adr_ready = 1'b1;
  logic        io_grant_safe = 1'b1;
  logic        io_resp_valid, io_resp_bits_last;
  logic [2:0]  io_resp_bits_opcode, io_resp_bits_param, io_resp_bits_source, io_resp_bits_sink;
  logic        io_resp_bits_denied, io_resp_bits_corrupt;
  logic [2:0]  io_source;
  logic        io_bs_adr_valid, io_bs_adr_bits_noop;
  logic [2:0]  io_bs_adr_bits_beat;
  logic [63:0] io_bs_dat_data;

  always #5 clock = ~clock;

  sink_d_param #(.DATA_W(64), .MAX_LG_SIZE(6), .SIZE_W(3), .SOURCE_W(3), .SINK_W(3), .DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .io_d_valid(io_d_valid), .io_d_ready(io_d_ready),
    .io_d_bits_opcode(io_d_bits_opcode), .io_d_bits_param(io_d_bits_param),
    .io_d_bits_size(io_d_bits_size), .io_d_bits_source(io_d_bits_source),
    .io_d_bits_sink(io_d_bits_sink), .io_d_bits_denied(io_d_bits_denied),
    .io_d_bits_data(io_d_bits_data), .io_d_bits_corrupt(io_d_bits_corrupt),
    .io_bs_adr_ready(io_bs_adr_ready), .io_grant_safe(io_grant_safe),
    .io_resp_valid(io_resp_valid), .io_resp_bits_last(io_resp_bits_last),
    .io_resp_bits_opcode(io_resp_bits_opcode), .io_resp_bits_param(io_resp_bits_param),
    .io_resp_bits_source(io_resp_bits_source), .io_resp_bits_sink(io_resp_bits_sink),
    .io_resp_bits_denied(io_resp_bits_denied), .io_resp_bits_corrupt(io_resp_bits_corrupt),
    .io_source(io_source), .io_bs_adr_valid(io_bs_adr_valid),
    .io_bs_adr_bits_noop(io_bs_adr_bits_noop), .io_bs_adr_bits_beat(io_bs_adr_bits_beat),
    .io_bs_dat_data(io_bs_dat_data)
  );

  typedef struct packed {
    logic       last;
    logic [2:0] opcode;
    logic [2:0] param;
    logic [2:0] source;
    logic [2:0] sink;
    logic       denied;
    logic       corrupt;
  } resp_t;

  typedef struct packed {
    logic [2:0]  beat;
    logic [63:0] data;
  } wr_t;

  resp_t resp_q[$];
  wr_t   wr_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    chk_en = 1'b1;
  bit    rand_ctl = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT presents a response or a bank-store write
  always @(negedge clock) begin
    resp_t e, a;
    wr_t   we, wa;
    if (reset && chk_en) begin
      if (io_resp_valid) begin
        a = {io_resp_bits_last, io_resp_bits_opcode, io_resp_bits_param, io_resp_bits_source,
             io_resp_bits_sink, io_resp_bits_denied, io_resp_bits_corrupt};
        if (resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_unexpected: got %0h expected no response", a);
        end else begin
          e = resp_q.pop_front();
          check("resp", 128'(a), 128'(e));
        end
        if (!io_resp_bits_opcode[0]) check("noop_nodata", 128'(io_bs_adr_bits_noop), 128'(1));
      end
      if (io_bs_adr_valid && io_bs_adr_ready && !io_bs_adr_bits_noop) begin
        wa = {io_bs_adr_bits_beat, io_bs_dat_data};
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL write_unexpected: got %0h expected no write", wa);
        end else begin
          we = wr_q.pop_front();
          check("bs_write", 128'(wa), 128'(we));
        end
      end
    end
  end

  // Random back-pressure on the bank store and grant gating
  initial forever begin
    @(posedge clock);
    #1;
    if (rand_ctl) begin
      io_bs_adr_ready = ($urandom_range(0, 3) != 0);
      io_grant_safe   = ($urandom_range(0, 1) == 1);
    end
  end

  // Present one beat from posedge+1 until it is accepted; returns at posedge+1
  task automatic drive_beat(input logic [2:0] op, input logic [1:0] prm, input logic [2:0] size,
                            input logic [2:0] src, input logic [2:0] snk, input logic den,
                            input logic [63:0] data, input logic cor);
    int t = 0;
    bit done = 1'b0;
    io_d_valid = 1'b1;
    io_d_bits_opcode = op; io_d_bits_param = prm; io_d_bits_size = size;
    io_d_bits_source = src; io_d_bits_sink = snk; io_d_bits_denied = den;
    io_d_bits_data = data; io_d_bits_corrupt = cor;
    while (!done) begin
      @(negedge clock);
      if (io_d_ready) done = 1'b1;
      tick();
      if (!done) begin
        t++;
        if (t > 500) begin
          checks++; errors++;
          $display("FAIL d_accept_timeout: got no ready after %0d cycles expected ready", t);
          done = 1'b1;
        end
      end
    end
    io_d_valid = 1'b0;
  endtask

  // Reference model: a message of 2^size bytes spans max(1, 2^size/8) beats if it carries data;
  // responses go out at the first and last beat, corruption accumulates over the message
  task automatic send_msg(input logic [2:0] op, input logic [2:0] size, input logic [2:0] src,
                          input logic [2:0] snk, input logic den, input logic [7:0] cmask);
    int nb;
    logic acc;
    resp_t r;
    wr_t w;
    logic [63:0] data [8];
    logic [1:0] prm;
    nb  = (op[0] && size > 3) ? (1 << (size - 3)) : 1;
    prm = 2'($urandom);
    acc = 1'b0;
    for (int b = 0; b < nb; b++) begin
      data[b] = {$urandom, $urandom};
      acc = acc | (cmask[b] & ~den);
      if (b == 0 || b == nb - 1) begin
        r.last = (b == nb - 1); r.opcode = op; r.param = {1'b0, prm};
        r.source = src; r.sink = snk; r.denied = den; r.corrupt = acc;
        resp_q.push_back(r);
      end
      if (op[0]) begin
        w.beat = 3'(b); w.data = data[b];
        wr_q.push_back(w);
      end
    end
    for (int b = 0; b < nb; b++) drive_beat(op, prm, size, src, snk, den, data[b], cmask[b]);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((resp_q.size() != 0 || wr_q.size() != 0) && t < 1000) begin
      tick();
      t++;
    end
    repeat (2) tick();
    check("drain_outstanding", 128'(resp_q.size() + wr_q.size()), 128'(0));
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clock);
    check({tag, "_d_ready"}, 128'(io_d_ready), 128'(0));
    check({tag, "_resp_valid"}, 128'(io_resp_valid), 128'(0));
    check({tag, "_adr_valid"}, 128'(io_bs_adr_valid), 128'(0));
    check({tag, "_noop"}, 128'(io_bs_adr_bits_noop), 128'(1));
    check({tag, "_source"}, 128'(io_source), 128'(0));
    check({tag, "_beat"}, 128'(io_bs_adr_bits_beat), 128'(0));
  endtask

  initial begin
    logic [2:0] ops [5];
    ops[0] = 3'd0; ops[1] = 3'd1; ops[2] = 3'd4; ops[3] = 3'd5; ops[4] = 3'd6;

    reset = 1'b0;
    repeat (3) tick();
    check_reset_state("reset");
    tick();
    reset = 1'b1;
    tick();

    // GrantData 8 beats, corruption on beat 3, then a clean burst
    send_msg(3'd5, 3'd6, 3'd2, 3'd1, 1'b0, 8'b0000_1000);
    send_msg(3'd5, 3'd6, 3'd3, 3'd4, 1'b0, 8'b0000_0000);
    // Single-beat AccessAck
    send_msg(3'd0, 3'd3, 3'd6, 3'd2, 1'b0, 8'b0);
    wait_drain();

    // Head held back by grant_safe
    io_grant_safe = 1'b0;
    send_msg(3'd0, 3'd3, 3'd5, 3'd0, 1'b0, 8'b0);
    @(negedge clock);
    check("gate_resp_valid", 128'(io_resp_valid), 128'(0));
    check("gate_adr_valid", 128'(io_bs_adr_valid), 128'(0));
    check("gate_source", 128'(io_source), 128'(5));
    tick();
    io_grant_safe = 1'b1;
    wait_drain();

    // FIFO full under back-pressure; order must survive
    io_bs_adr_ready = 1'b0;
    fork
      begin
        send_msg(3'd1, 3'd3, 3'd1, 3'd1, 1'b0, 8'b0);
        send_msg(3'd1, 3'd3, 3'd2, 3'd2, 1'b0, 8'b0);
        send_msg(3'd1, 3'd3, 3'd3, 3'd3, 1'b0, 8'b0);
      end
      begin
        repeat (4) tick();
        @(negedge clock);
        check("full_d_ready", 128'(io_d_ready), 128'(0));
        tick();
        io_bs_adr_ready = 1'b1;
      end
    join
    wait_drain();

    // Randomized traffic with random back-pressure
    rand_ctl = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_msg(ops[$urandom_range(0, 4)], 3'($urandom_range(0, 6)), 3'($urandom),
               3'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom) & 8'($urandom));
    end
    rand_ctl = 1'b0;
    tick();
    io_bs_adr_ready = 1'b1;
    io_grant_safe   = 1'b1;
    wait_drain();

    // Reset in the middle of an 8-beat burst
    chk_en = 1'b0;
    for (int b = 0; b < 4; b++) drive_beat(3'd5, 2'd0, 3'd6, 3'd7, 3'd7, 1'b0, {$urandom, $urandom}, 1'b1);
    reset = 1'b0;
    repeat (2) tick();
    check_reset_state("midreset");
    resp_q.delete();
    wr_q.delete();
    reset = 1'b1;
    chk_en = 1'b1;
    tick();
    send_msg(3'd0, 3'd0, 3'd4, 3'd3, 1'b0, 8'b0);
    send_msg(3'd5, 3'd4, 3'd1, 3'd5, 1'b0, 8'b0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
